// File: rtl/sbox_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_scheduler
//  Purpose  : Time-shares one external combinational AES S-box between a
//             128-bit SubBytes requester and a 32-bit SubWord requester,
//             substituting one byte per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_scheduler #(
   parameter int ARB_MODE = 0   // 0: round-robin, 1: word requester has priority
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         state_req_valid,
   input  logic [127:0] state_req_data,
   output logic         state_req_ready,
   output logic         state_resp_valid,
   output logic [127:0] state_resp_data,
   input  logic         word_req_valid,
   input  logic [31:0]  word_req_data,
   output logic         word_req_ready,
   output logic         word_resp_valid,
   output logic [31:0]  word_resp_data,
   output logic [7:0]   sbox_addr,
   input  logic [7:0]   sbox_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUB_STATE = 2'd1,
      SUB_WORD  = 2'd2
   } state_t;

   state_t         state_q;
   logic [127:0]   buf_q;          // captured request, consumed MSB byte first
   logic [127:0]   work_q;         // substituted bytes, shifted in at the LSB end
   logic [3:0]     cnt_q;
   logic           last_word_q;    // 1: word requester was granted most recently
   logic           state_resp_valid_q;
   logic           word_resp_valid_q;
   logic [127:0]   state_resp_data_q;
   logic [31:0]    word_resp_data_q;

   logic           grant_word;
   logic           grant_state;
   logic           last_byte;

   // Arbitration: word wins alone, under fixed priority, or when state went last
   always_comb begin
      grant_word  = word_req_valid &&
                    (!state_req_valid || (ARB_MODE == 1) || !last_word_q);
      grant_state = state_req_valid && !grant_word;
      last_byte   = ((state_q == SUB_STATE) && (cnt_q == 4'd15)) ||
                    ((state_q == SUB_WORD)  && (cnt_q == 4'd3));
   end

   assign state_req_ready  = (state_q == IDLE) && grant_state;
   assign word_req_ready   = (state_q == IDLE) && grant_word;
   assign busy             = (state_q != IDLE);
   // Buffer shifts left each substitution, so the current byte is always on top
   assign sbox_addr        = (state_q == IDLE) ? 8'h00 : buf_q[127:120];
   assign state_resp_valid = state_resp_valid_q;
   assign word_resp_valid  = word_resp_valid_q;
   assign state_resp_data  = state_resp_data_q;
   assign word_resp_data   = word_resp_data_q;

   // Scheduler FSM: accept, walk the bytes through the S-box, publish result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= IDLE;
         buf_q              <= '0;
         work_q             <= '0;
         cnt_q              <= 4'd0;
         last_word_q        <= 1'b0;
         state_resp_valid_q <= 1'b0;
         word_resp_valid_q  <= 1'b0;
         state_resp_data_q  <= '0;
         word_resp_data_q   <= '0;
      end else begin
         state_resp_valid_q <= 1'b0;
         word_resp_valid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_word) begin
                  buf_q       <= {word_req_data, 96'h0};
                  cnt_q       <= 4'd0;
                  last_word_q <= 1'b1;
                  state_q     <= SUB_WORD;
               end else if (grant_state) begin
                  buf_q       <= state_req_data;
                  cnt_q       <= 4'd0;
                  last_word_q <= 1'b0;
                  state_q     <= SUB_STATE;
               end
            end
            SUB_STATE, SUB_WORD: begin
               buf_q  <= {buf_q[119:0], 8'h00};
               work_q <= {work_q[119:0], sbox_data};
               if (last_byte) begin
                  cnt_q   <= 4'd0;
                  state_q <= IDLE;
                  if (state_q == SUB_STATE) begin
                     state_resp_data_q  <= {work_q[119:0], sbox_data};
                     state_resp_valid_q <= 1'b1;
                  end else begin
                     word_resp_data_q   <= {work_q[23:0], sbox_data};
                     word_resp_valid_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sbox_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_scheduler
//  Purpose  : Directed self-checking bench for sbox_scheduler (both ARB modes)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_scheduler;

   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [127:0] ST_IN   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ST_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [31:0]  WD_IN   = 32'hcf4f3c09;
   localparam logic [31:0]  WD_OUT  = 32'h8a84eb01;
   localparam logic [127:0] ST_63   = 128'h63636363636363636363636363636363;

   function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
      int idx;
      idx = int'(a);
      return SBOX_TAB[2047 - 8*idx -: 8];
   endfunction

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT0: round-robin
   logic s_v, s_r, s_rv, w_v, w_r, w_rv, busy0;
   logic [127:0] s_d, s_rd;
   logic [31:0]  w_d, w_rd;
   logic [7:0]   addr0, data0;
   assign data0 = sbox_lookup(addr0);

   // DUT1: fixed priority to word
   logic s_v1, s_r1, s_rv1, w_v1, w_r1, w_rv1, busy1;
   logic [127:0] s_d1, s_rd1;
   logic [31:0]  w_d1, w_rd1;
   logic [7:0]   addr1, data1;
   assign data1 = sbox_lookup(addr1);

   sbox_scheduler #(.ARB_MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .state_req_valid(s_v), .state_req_data(s_d), .state_req_ready(s_r),
      .state_resp_valid(s_rv), .state_resp_data(s_rd),
      .word_req_valid(w_v), .word_req_data(w_d), .word_req_ready(w_r),
      .word_resp_valid(w_rv), .word_resp_data(w_rd),
      .sbox_addr(addr0), .sbox_data(data0), .busy(busy0));

   sbox_scheduler #(.ARB_MODE(1)) dut1 (
      .clk(clk), .rst(rst),
      .state_req_valid(s_v1), .state_req_data(s_d1), .state_req_ready(s_r1),
      .state_resp_valid(s_rv1), .state_resp_data(s_rd1),
      .word_req_valid(w_v1), .word_req_data(w_d1), .word_req_ready(w_r1),
      .word_resp_valid(w_rv1), .word_resp_data(w_rd1),
      .sbox_addr(addr1), .sbox_data(data1), .busy(busy1));

   int total = 0;
   int bad   = 0;

   // Waits for a response pulse; sel 0/1 = dut0 state/word, 2/3 = dut1 state/word.
   // lat = posedges until the pulse is seen (-1 on timeout).
   task automatic wait_resp(input int sel, input int limit, output int lat, output int bc);
      logic b;
      lat = -1;
      b   = (sel < 2) ? busy0 : busy1;
      bc  = b ? 1 : 0;
      for (int n = 1; n <= limit; n++) begin
         @(posedge clk); #1;
         b = (sel < 2) ? busy0 : busy1;
         if ((sel == 0 && s_rv) || (sel == 1 && w_rv) || (sel == 2 && s_rv1) || (sel == 3 && w_rv1)) begin
            lat = n;
            break;
         end
         if (b) bc++;
      end
   endtask

   task automatic test_reset;
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy0); end
      total++; if (s_rv !== 1'b0 || w_rv !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b%b want=00", s_rv, w_rv); end
      total++; if (s_rd !== 128'h0) begin bad++; $display("FAIL rst_srd got=%h want=0", s_rd); end
      total++; if (w_rd !== 32'h0) begin bad++; $display("FAIL rst_wrd got=%h want=0", w_rd); end
      total++; if (addr0 !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", addr0); end
      total++; if (s_r !== 1'b0 || w_r !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b want=00", s_r, w_r); end
      w_v = 1'b1; #1;
      total++; if (w_r !== 1'b1 || s_r !== 1'b0) begin bad++; $display("FAIL single_word_ready got=%b%b want=01", s_r, w_r); end
      w_v = 1'b0;
   endtask

   task automatic test_state;
      int lat, bc;
      s_d = ST_IN; s_v = 1'b1; #1;
      total++; if (s_r !== 1'b1 || w_r !== 1'b0) begin bad++; $display("FAIL state_ready got=%b%b want=10", s_r, w_r); end
      @(posedge clk); #1;
      s_v = 1'b0; s_d = '1;
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL state_busy got=%b want=1", busy0); end
      wait_resp(0, 40, lat, bc);
      total++; if (lat !== 16) begin bad++; $display("FAIL state_latency got=%0d want=16", lat); end
      total++; if (bc !== 16) begin bad++; $display("FAIL state_busy_cycles got=%0d want=16", bc); end
      total++; if (s_rd !== ST_OUT) begin bad++; $display("FAIL state_data got=%h want=%h", s_rd, ST_OUT); end
      @(posedge clk); #1;
      total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL state_pulse got=%b want=0", s_rv); end
      total++; if (s_rd !== ST_OUT) begin bad++; $display("FAIL state_hold got=%h want=%h", s_rd, ST_OUT); end
   endtask

   task automatic test_word;
      int lat, bc;
      w_d = WD_IN; w_v = 1'b1; #1;
      total++; if (w_r !== 1'b1) begin bad++; $display("FAIL word_ready got=%b want=1", w_r); end
      @(posedge clk); #1;
      w_v = 1'b0; w_d = 32'h0;
      total++; if (addr0 !== 8'hcf) begin bad++; $display("FAIL word_addr0 got=%h want=cf", addr0); end
      @(posedge clk); #1;
      total++; if (addr0 !== 8'h4f) begin bad++; $display("FAIL word_addr1 got=%h want=4f", addr0); end
      wait_resp(1, 20, lat, bc);
      total++; if (lat + 1 !== 4) begin bad++; $display("FAIL word_latency got=%0d want=4", lat + 1); end
      total++; if (w_rd !== WD_OUT) begin bad++; $display("FAIL word_data got=%h want=%h", w_rd, WD_OUT); end
      total++; if (s_rd !== ST_OUT) begin bad++; $display("FAIL word_state_untouched got=%h want=%h", s_rd, ST_OUT); end
   endtask

   task automatic test_data_change;
      int lat, bc;
      s_d = 128'h0; s_v = 1'b1;
      @(posedge clk); #1;
      s_v = 1'b0; s_d = '1;
      wait_resp(0, 40, lat, bc);
      total++; if (lat !== 16) begin bad++; $display("FAIL chg_latency got=%0d want=16", lat); end
      total++; if (s_rd !== ST_63) begin bad++; $display("FAIL chg_data got=%h want=%h", s_rd, ST_63); end
   endtask

   task automatic test_rr_tie;
      int lat, bc;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      s_d = ST_IN; w_d = WD_IN; s_v = 1'b1; w_v = 1'b1; #1;
      total++; if (w_r !== 1'b1 || s_r !== 1'b0) begin bad++; $display("FAIL rr_first got=%b%b want=01", s_r, w_r); end
      @(posedge clk); #1;
      wait_resp(1, 20, lat, bc);
      total++; if (lat !== 4) begin bad++; $display("FAIL rr_word_latency got=%0d want=4", lat); end
      total++; if (w_rd !== WD_OUT) begin bad++; $display("FAIL rr_word_data got=%h want=%h", w_rd, WD_OUT); end
      total++; if (s_r !== 1'b1 || w_r !== 1'b0) begin bad++; $display("FAIL rr_second got=%b%b want=10", s_r, w_r); end
      @(posedge clk); #1;
      s_v = 1'b0;
      total++; if (busy0 !== 1'b1 || w_r !== 1'b0) begin bad++; $display("FAIL rr_state_running got=%b%b want=10", busy0, w_r); end
      wait_resp(0, 40, lat, bc);
      total++; if (lat !== 16) begin bad++; $display("FAIL rr_state_latency got=%0d want=16", lat); end
      total++; if (s_rd !== ST_OUT) begin bad++; $display("FAIL rr_state_data got=%h want=%h", s_rd, ST_OUT); end
      s_v = 1'b1; #1;
      total++; if (w_r !== 1'b1 || s_r !== 1'b0) begin bad++; $display("FAIL rr_third got=%b%b want=01", s_r, w_r); end
      s_v = 1'b0;
      @(posedge clk); #1;
      w_v = 1'b0;
      wait_resp(1, 20, lat, bc);
      total++; if (lat !== 4) begin bad++; $display("FAIL rr_word2_latency got=%0d want=4", lat); end
   endtask

   task automatic test_fixed;
      int lat, bc;
      s_d1 = ST_IN; w_d1 = WD_IN; s_v1 = 1'b1; w_v1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (s_r1 !== 1'b0 || w_r1 !== 1'b1) begin bad++; $display("FAIL fixed_tie%0d got=%b%b want=01", k, s_r1, w_r1); end
         @(posedge clk); #1;
         w_v1 = 1'b0;
         wait_resp(3, 20, lat, bc);
         total++; if (lat !== 4 || w_rd1 !== WD_OUT) begin bad++; $display("FAIL fixed_word%0d got=%0d/%h want=4/%h", k, lat, w_rd1, WD_OUT); end
         w_v1 = 1'b1;
      end
      w_v1 = 1'b0; #1;
      total++; if (s_r1 !== 1'b1) begin bad++; $display("FAIL fixed_state_ready got=%b want=1", s_r1); end
      @(posedge clk); #1;
      s_v1 = 1'b0;
      wait_resp(2, 40, lat, bc);
      total++; if (lat !== 16 || s_rd1 !== ST_OUT) begin bad++; $display("FAIL fixed_state got=%0d/%h want=16/%h", lat, s_rd1, ST_OUT); end
   endtask

   task automatic test_reset_mid;
      int lat, bc, pulses;
      s_d = ST_IN; s_v = 1'b1;
      @(posedge clk); #1;
      s_v = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst = 1'b1; #1;
      total++; if (busy0 !== 1'b0 || addr0 !== 8'h00) begin bad++; $display("FAIL mid_rst_idle got=%b/%h want=0/00", busy0, addr0); end
      total++; if (s_rd !== 128'h0 || w_rd !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h/%h want=0/0", s_rd, w_rd); end
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (s_rv || w_rv) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_pulses got=%0d want=0", pulses); end
      w_d = WD_IN; w_v = 1'b1;
      @(posedge clk); #1;
      w_v = 1'b0;
      wait_resp(1, 20, lat, bc);
      total++; if (lat !== 4 || w_rd !== WD_OUT) begin bad++; $display("FAIL mid_rst_word got=%0d/%h want=4/%h", lat, w_rd, WD_OUT); end
      total++; if (s_rd !== 128'h0) begin bad++; $display("FAIL mid_rst_state_zero got=%h want=0", s_rd); end
   endtask

   initial begin
      s_v = 1'b0; s_d = '0; w_v = 1'b0; w_d = '0;
      s_v1 = 1'b0; s_d1 = '0; w_v1 = 1'b0; w_d1 = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      test_reset;
      test_state;
      test_word;
      test_data_change;
      test_rr_tie;
      test_fixed;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sbox_scheduler.md
SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0; 0 = round-robin between requesters, 1 = fixed priority to word requester.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port state_req_valid  input  1  SubBytes request present.
REQ-005 SHALL have port state_req_data  input  128  state to substitute; byte i = bits [127-8i -: 8], i = 0..15.
REQ-006 SHALL have port state_req_ready  output  1  state request accepted on edge where valid && ready.
REQ-007 SHALL have port state_resp_valid  output  1  one-cycle pulse, state result ready.
REQ-008 SHALL have port state_resp_data  output  128  substituted state, same byte order as input.
REQ-009 SHALL have port word_req_valid  input  1  SubWord (key expansion) request present.
REQ-010 SHALL have port word_req_data  input  32  word to substitute; byte i = bits [31-8i -: 8], i = 0..3.
REQ-011 SHALL have port word_req_ready  output  1  word request accepted on edge where valid && ready.
REQ-012 SHALL have port word_resp_valid  output  1  one-cycle pulse, word result ready.
REQ-013 SHALL have port word_resp_data  output  32  substituted word.
REQ-014 SHALL have port sbox_addr  output  8  address to the single shared combinational sbox instance.
REQ-015 SHALL have port sbox_data  input  8  sbox output for sbox_addr, same cycle.
REQ-016 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SUB_STATE, SUB_WORD.
REQ-018 In IDLE, at most one ready SHALL be high; the ready of the winning requester is high when its valid is high (ready may depend combinationally on both valids); both readies low outside IDLE.
REQ-019 Arbitration, single valid: that requester wins; both valid, ARB_MODE=1: word wins; ARB_MODE=0: requester not granted last wins, pointer updated on each acceptance.
REQ-020 On acceptance: request data captured into an internal buffer, byte counter cleared to 0, FSM goes to SUB_STATE or SUB_WORD.
REQ-021 In SUB_* each cycle: sbox_addr = captured byte[counter]; on the rising edge result byte[counter] <= sbox_data, counter increments.
REQ-022 SUB_STATE exits after byte 15, SUB_WORD after byte 3; on that edge FSM -> IDLE and the matching resp_valid is registered high for exactly one cycle.
REQ-023 Latency: resp_valid high 16 cycles (state) / 4 cycles (word) after the acceptance edge; next acceptance possible in the resp_valid cycle, i.e. 17 / 5 cycles per transaction back-to-back.
REQ-024 resp_data SHALL be registered, written only at completion, and held until the next completion of the same type.
REQ-025 Requester valid/data changes after acceptance SHALL be ignored; a losing requester keeps waiting with no data loss (its valid must stay high per protocol).
REQ-026 sbox_addr SHALL be 8'h00 in IDLE.
REQ-027 Counter width 4 bits; no wrap beyond 15 occurs because FSM leaves SUB_STATE at 15.

Reset
REQ-028 rst high SHALL asynchronously force: FSM IDLE, counter 0, both resp_valid 0, both resp_data 0, buffer 0, RR pointer = state-granted-last (first tie goes to word), busy 0.
REQ-029 Reset mid-transaction SHALL abort it with no resp_valid pulse; first acceptance after release behaves as after power-up.

Verification
REQ-030 State 128'h00112233445566778899aabbccddeeff -> state_resp_valid 16 cycles after acceptance, data 128'h638293c31bfc33f5c4eeacea4bc12816, busy high for those 16 cycles.
REQ-031 Word 32'hcf4f3c09 -> word_resp_valid 4 cycles after acceptance, data 32'h8a84eb01; state_resp_data unchanged.
REQ-032 ARB_MODE=0, both valid from reset, held -> word served first, state accepted in word resp cycle; next simultaneous tie granted to word again only after state served.
REQ-033 ARB_MODE=1, word valid re-asserted every time IDLE is reached -> state_req_ready never high while word_req_valid high.
REQ-034 rst asserted at byte 7 of state job -> no resp pulse, outputs zero, new word request then completes in 4 cycles correctly.
REQ-035 Change state_req_data to all 8'hff one cycle after acceptance of 128'h0 -> result 128'h63636363636363636363636363636363.
